// File: rtl/rnn_readout_if.sv
// Shared hidden/weight memory read port plus the result stream of rnn_readout.
// The readout block drives the master side; memory and consumer sit on the slave side.
interface rnn_readout_if;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_r;
    logic        o_valid;
    logic        o_ready;
    logic [19:0] o_data;
    logic [10:0] o_tidx;
    logic [1:0]  o_oidx;

    modport master (
        output mce, msel, maddr, o_valid, o_data, o_tidx, o_oidx,
        input  mdata_r, o_ready
    );

    modport slave (
        input  mce, msel, maddr, o_valid, o_data, o_tidx, o_oidx,
        output mdata_r, o_ready
    );
endinterface

// File: rtl/rnn_readout.sv
// Output projection y[t][o] = sum_h V[o][h]*h[t][h] + c[o] over the shared hidden-state memory,
// streamed out in (t, o) order with a 48-bit accumulator and saturating Q4.16 rounding.
module rnn_readout #(
    parameter int N_OUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [10:0]   t_len,
    output logic          busy,
    output logic          done,
    rnn_readout_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD_H, BIAS, MAC, DRAIN, ROUND, OUT, DONE} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_HID, RD_BIAS, RD_WGT} rd_kind_t;

    localparam logic [1:0] O_LAST = 2'(N_OUT - 1);

    state_t             state, state_next;
    rd_kind_t           rd_kind, rd_kind_d;
    logic [5:0]         rd_idx_d;
    logic [10:0]        t_len_r;
    logic [10:0]        t;
    logic [1:0]         o;
    logic [5:0]         cnt;
    logic               busy_r;
    logic               last_o, last_t;
    logic signed [19:0] hbuf [64];
    logic signed [39:0] prod;
    logic signed [47:0] acc;
    logic signed [47:0] acc_rnd, acc_shift;
    logic [19:0]        r_sat;

    assign last_o = (o == O_LAST);
    assign last_t = (t == t_len_r - 11'd1);
    assign busy   = busy_r;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus the read issued this cycle; rd_kind tags what comes back next cycle.
    always_comb begin
        state_next  = state;
        rd_kind     = RD_NONE;
        bus.mce     = 1'b0;
        bus.msel    = 3'b000;
        bus.maddr   = '0;
        bus.o_valid = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (t_len == 11'd0) ? DONE : LOAD_H;
            end
            LOAD_H: begin
                rd_kind   = RD_HID;
                bus.mce   = 1'b1;
                bus.msel  = 3'b101;
                bus.maddr = {t, cnt};
                if (cnt == 6'd63) state_next = BIAS;
            end
            BIAS: begin
                rd_kind    = RD_BIAS;
                bus.mce    = 1'b1;
                bus.msel   = 3'b111;
                bus.maddr  = {15'b0, o};
                state_next = MAC;
            end
            MAC: begin
                rd_kind   = RD_WGT;
                bus.mce   = 1'b1;
                bus.msel  = 3'b110;
                bus.maddr = {9'b0, o, cnt};
                if (cnt == 6'd63) state_next = DRAIN;
            end
            DRAIN: state_next = ROUND;
            ROUND: state_next = OUT;
            OUT: begin
                bus.o_valid = 1'b1;
                if (bus.o_ready) begin
                    if (!last_o)      state_next = BIAS;
                    else if (!last_t) state_next = LOAD_H;
                    else              state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign prod = 40'($signed(bus.mdata_r)) * 40'(hbuf[rd_idx_d]);

    assign acc_rnd   = acc + 48'sd32768;
    assign acc_shift = acc_rnd >>> 16;

    always_comb begin
        if (acc_shift > 48'sd524287)       r_sat = 20'h7FFFF;
        else if (acc_shift < -48'sd524288) r_sat = 20'h80000;
        else                               r_sat = acc_shift[19:0];
    end

    // Hidden words land one cycle after their address, so the write uses the delayed index.
    always_ff @(posedge clk) begin
        if (rd_kind_d == RD_HID) hbuf[rd_idx_d] <= bus.mdata_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_len_r    <= '0;
            t          <= '0;
            o          <= '0;
            cnt        <= '0;
            busy_r     <= 1'b0;
            rd_kind_d  <= RD_NONE;
            rd_idx_d   <= '0;
            acc        <= '0;
            bus.o_data <= '0;
            bus.o_tidx <= '0;
            bus.o_oidx <= '0;
        end else begin
            rd_kind_d <= rd_kind;
            rd_idx_d  <= cnt;
            case (rd_kind_d)
                RD_BIAS: acc <= {{12{bus.mdata_r[19]}}, bus.mdata_r, 16'b0};
                RD_WGT:  acc <= acc + 48'(prod);
                default: ;
            endcase
            case (state)
                IDLE: begin
                    if (start) begin
                        t_len_r <= t_len;
                        t       <= '0;
                        o       <= '0;
                        cnt     <= '0;
                        busy_r  <= (t_len != 11'd0);
                    end
                end
                LOAD_H, MAC: cnt <= cnt + 6'd1;
                ROUND: begin
                    bus.o_data <= r_sat;
                    bus.o_tidx <= t;
                    bus.o_oidx <= o;
                end
                OUT: begin
                    if (bus.o_ready) begin
                        if (!last_o) begin
                            o <= o + 2'd1;
                        end else if (!last_t) begin
                            t <= t + 11'd1;
                            o <= '0;
                        end
                    end
                end
                DONE: busy_r <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
